instruction_fetch_unit: RTL

//  IF-stage initiator for the word-addressed, combinational-read instruction memory.

---
 rtl/rv_pipeline_pkg.sv | 34 +++
 rtl/instruction_fetch_unit_if_id_reg.sv | 66 ++++++
 rtl/instruction_fetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/rv_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipeline_pkg
// Shared definitions for the in-order RV32 pipeline front end.
//   XLEN              datapath width
//   NOP_INSTR_DEF     default bubble encoding (addi x0,x0,0)
//   RESET_PC_DEF      default PC after reset
//   if_id_t           IF/ID pipeline register bundle
//   if_id_reset_val   value the IF/ID register takes on reset
// ---------------------------------------------------------------------------
package rv_pipeline_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            fault;
    } if_id_t;

    function automatic if_id_t if_id_reset_val(input logic [XLEN-1:0] nop);
        if_id_t r;
        r.instr    = nop;
        r.pc       = '0;
        r.pc_plus4 = '0;
        r.valid    = 1'b0;
        r.fault    = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with priority reset > flush > stall > capture.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold every field (including fault)
//   flush                    insert a bubble (NOP, valid=0, fault=0)
//   cap_*                    values to capture when neither flush nor stall
//   instr, pc, pc_plus4,
//   valid, fault             registered IF/ID contents
// ---------------------------------------------------------------------------
module if_id_reg
    import rv_pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] cap_instr,
    input  logic [31:0] cap_pc,
    input  logic [31:0] cap_pc_plus4,
    input  logic        cap_valid,
    input  logic        cap_fault,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        fault
);

    if_id_t if_id_d;
    if_id_t if_id_q;

    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            // PC fields are don't-care in a bubble; holding them avoids extra muxing.
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
            if_id_d.fault = 1'b0;
        end else if (!stall) begin
            if_id_d.instr    = cap_instr;
            if_id_d.pc       = cap_pc;
            if_id_d.pc_plus4 = cap_pc_plus4;
            if_id_d.valid    = cap_valid;
            if_id_d.fault    = cap_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= if_id_reset_val(NOP_INSTR);
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign instr    = if_id_q.instr;
    assign pc       = if_id_q.pc;
    assign pc_plus4 = if_id_q.pc_plus4;
    assign valid    = if_id_q.valid;
    assign fault    = if_id_q.fault;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage: owns the PC, addresses a combinational-read, word-addressed
// instruction memory, captures the returned word into IF/ID and advances PC
// by 4. Handles stall, flush and redirect, and flags misaligned or
// out-of-range fetches.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_if          hold PC and IF/ID
//   flush_if          bubble into IF/ID next edge
//   redirect_valid    load redirect_pc into PC next edge (IF/ID gets a bubble)
//   redirect_pc       byte-address target, loaded verbatim
//   imem_addr         word index {2'b00, pc[31:2]} (combinational from PC)
//   imem_rd           instruction word returned in the same cycle
//   pc_out            current PC (combinational from PC register)
//   if_id_*           registered IF/ID contents
//   fetch_count       valid instructions captured since reset (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import rv_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        flush_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        if_id_fault,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;
    logic [31:0] fetch_count_d;
    logic [31:0] fetch_count_q;
    logic [31:0] pc_plus4;
    logic        fault_now;
    logic        bubble;
    logic [31:0] cap_instr;

    assign pc_plus4  = pc_q + 32'd4;   // wraps naturally at 32'hFFFF_FFFC
    assign imem_addr = {2'b00, pc_q[31:2]};
    assign pc_out    = pc_q;

    // Word index is compared zero-extended so any depth up to 2^30 works.
    assign fault_now = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= 32'(IMEM_DEPTH));

    // A redirect squashes the instruction fetched down the wrong path.
    assign bubble    = flush_if | redirect_valid;
    assign cap_instr = fault_now ? NOP_INSTR : imem_rd;

    always_comb begin
        pc_d = pc_plus4;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall_if) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (!bubble && !stall_if && !fault_now) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall_if),
        .flush        (bubble),
        .cap_instr    (cap_instr),
        .cap_pc       (pc_q),
        .cap_pc_plus4 (pc_plus4),
        .cap_valid    (~fault_now),
        .cap_fault    (fault_now),
        .instr        (if_id_instr),
        .pc           (if_id_pc),
        .pc_plus4     (if_id_pc_plus4),
        .valid        (if_id_valid),
        .fault        (if_id_fault)
    );

endmodule
